// File: rtl/dbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module : dbuf_pkg
// Brief  : Shared types and default geometry for the ping-pong stream buffer.
// Rev    : 1.0
// ============================================================================
package dbuf_pkg;

    localparam int c_def_awidth      = 12;
    localparam int c_def_dwidth      = 40;
    localparam int c_def_frame_words = 4096;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // A bank is owned by the reader from the moment it closes until its last read issues.
    function automatic logic bank_busy(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbuf_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module : dbuf_skid_fifo
// Brief  : Two-entry output FIFO; occupancy feeds the read-credit logic.
// Rev    : 1.0
// ============================================================================
module dbuf_skid_fifo #(
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_mem0;
    assign o_count = r_count;

    // Slot 0 is always the head; a pop shifts slot 1 forward.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= i_data;
                    else                 r_mem1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbuf_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dbuf_stream_ctrl
// Brief  : Frame-granular ping-pong sequencer for two dual-port RAM banks.
// Rev    : 1.0
// ============================================================================
module dbuf_stream_ctrl
    import dbuf_pkg::*;
#(
    parameter int AWIDTH      = c_def_awidth,
    parameter int DWIDTH      = c_def_dwidth,
    parameter int FRAME_WORDS = c_def_frame_words
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [AWIDTH-1:0] ram0_address_a,
    output logic              ram0_wren_a,
    output logic [DWIDTH-1:0] ram0_data_a,
    output logic [AWIDTH-1:0] ram0_address_b,
    output logic              ram0_wren_b,
    input  logic [DWIDTH-1:0] ram0_out_b,
    output logic [AWIDTH-1:0] ram1_address_a,
    output logic              ram1_wren_a,
    output logic [DWIDTH-1:0] ram1_data_a,
    output logic [AWIDTH-1:0] ram1_address_b,
    output logic              ram1_wren_b,
    input  logic [DWIDTH-1:0] ram1_out_b,
    output logic [1:0]        bank_full
);

    localparam logic [AWIDTH-1:0] c_last_idx = AWIDTH'(FRAME_WORDS - 1);

    bank_state_t       r_state [2];
    logic [AWIDTH:0]   r_len   [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [AWIDTH-1:0] r_wr_cnt;
    logic [AWIDTH-1:0] r_rd_cnt;
    logic              r_run;
    logic              r_if_valid;
    logic              r_if_bank;
    logic              r_if_last;

    logic              w_wr_fire;
    logic              w_wr_close;
    logic              w_rd_active;
    logic              w_rd_issue;
    logic              w_rd_final;
    logic              w_pop;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_occ;
    logic [DWIDTH:0]   w_fifo_head;
    logic [DWIDTH:0]   w_fifo_in;
    logic [1:0]        w_wr_en;
    logic [AWIDTH-1:0] w_wr_addr [2];
    logic [DWIDTH-1:0] w_wr_data [2];
    logic [AWIDTH-1:0] w_rd_addr [2];
    logic [1:0]        w_busy;

    // r_run keeps in_ready low for the whole reset, including the async assertion.
    assign in_ready    = r_run && !bank_busy(r_state[r_wr_bank]);
    assign w_wr_fire   = in_valid && in_ready;
    assign w_wr_close  = w_wr_fire && (in_last || (r_wr_cnt == c_last_idx));

    assign out_valid   = (w_fifo_count != 2'd0);
    assign out_data    = out_valid ? w_fifo_head[DWIDTH-1:0] : '0;
    assign out_last    = out_valid && w_fifo_head[DWIDTH];
    assign w_pop       = out_valid && out_ready;

    // A slot freed by this cycle's pop can be re-used by this cycle's read.
    assign w_occ       = {1'b0, w_fifo_count} + {2'b00, r_if_valid};
    assign w_rd_active = bank_busy(r_state[r_rd_bank]);
    assign w_rd_issue  = w_rd_active && (w_occ < (3'd2 + {2'b00, w_pop}));
    assign w_rd_final  = (({1'b0, r_rd_cnt} + 1'b1) == r_len[r_rd_bank]);

    assign w_fifo_in   = {r_if_last, (r_if_bank ? ram1_out_b : ram0_out_b)};

    for (genvar k = 0; k < 2; k++) begin : g_bank
        assign w_wr_en[k]   = w_wr_fire && (r_wr_bank == 1'(k));
        assign w_wr_addr[k] = w_wr_en[k] ? r_wr_cnt : '0;
        assign w_wr_data[k] = w_wr_en[k] ? in_data : '0;
        assign w_rd_addr[k] = (w_rd_issue && (r_rd_bank == 1'(k))) ? r_rd_cnt : '0;
        assign w_busy[k]    = bank_busy(r_state[k]);
    end

    assign ram0_address_a = w_wr_addr[0];
    assign ram0_wren_a    = w_wr_en[0];
    assign ram0_data_a    = w_wr_data[0];
    assign ram0_address_b = w_rd_addr[0];
    assign ram0_wren_b    = 1'b0;
    assign ram1_address_a = w_wr_addr[1];
    assign ram1_wren_a    = w_wr_en[1];
    assign ram1_data_a    = w_wr_data[1];
    assign ram1_address_b = w_rd_addr[1];
    assign ram1_wren_b    = 1'b0;
    assign bank_full      = w_busy;

    // Writer and reader never touch the same bank in one cycle: the writer only
    // owns EMPTY/FILLING banks, the reader only FULL/DRAINING ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_run      <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_bank  <= 1'b0;
            r_if_last  <= 1'b0;
        end else begin
            r_run <= 1'b1;

            if (w_wr_fire) begin
                if (w_wr_close) begin
                    r_state[r_wr_bank] <= BANK_FULL;
                    r_len[r_wr_bank]   <= {1'b0, r_wr_cnt} + 1'b1;
                    r_wr_cnt           <= '0;
                    r_wr_bank          <= ~r_wr_bank;
                end else begin
                    r_state[r_wr_bank] <= BANK_FILLING;
                    r_wr_cnt           <= r_wr_cnt + 1'b1;
                end
            end

            r_if_valid <= w_rd_issue;
            r_if_bank  <= r_rd_bank;
            r_if_last  <= w_rd_final;

            if (w_rd_issue) begin
                if (w_rd_final) begin
                    r_state[r_rd_bank] <= BANK_EMPTY;
                    r_rd_cnt           <= '0;
                    r_rd_bank          <= ~r_rd_bank;
                end else begin
                    r_state[r_rd_bank] <= BANK_DRAINING;
                    r_rd_cnt           <= r_rd_cnt + 1'b1;
                end
            end else if (r_state[r_rd_bank] == BANK_FULL) begin
                r_state[r_rd_bank] <= BANK_DRAINING;
            end
        end
    end

    dbuf_skid_fifo #(
        .WIDTH (DWIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (r_if_valid),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count)
    );

endmodule
`default_nettype wire
